// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for synchronous_fifo. Issues FIFO reads
// and presents the words as a valid/ready stream. A 2-entry buffer (head plus
// skid) absorbs the FIFO's 1-cycle read latency, so the stream can move one
// word per cycle.
// Optional build macro: FIFO_RD_STATS_EN adds the word_cnt and stall_cnt
// statistics counters. When it is undefined, both outputs are tied to 0.
//
// state   | meaning
// S_EMPTY | no buffered word, m_valid=0
// S_ONE   | head holds the next word
// S_TWO   | head and skid both hold words, skid is the younger one
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  // The encoding equals the buffer occupancy so it can be used directly in the slot arithmetic.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_e;

  buf_state_e            state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push, pop;
  logic [1:0]            occ;
  logic [1:0]            level;

  assign occ     = state_q;
  assign push    = inflight_q;
  assign m_valid = (state_q != S_EMPTY);
  assign m_data  = head_q;
  assign pop     = m_valid & m_ready;

  // A new read is allowed only while a buffer slot is still free after this cycle's pop.
  // A pop implies occ>=1, so the 2-bit subtraction cannot underflow.
  always_comb begin
    level      = occ + {1'b0, inflight_q} - {1'b0, pop};
    fifo_r_en  = rst_n & ~fifo_empty & (level < 2'd2);
    inflight_d = fifo_r_en;
  end

  // Buffer next state: the returning read word is pushed and the head is popped.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_d  = fifo_rd_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        case ({push, pop})
          2'b10: begin
            skid_d  = fifo_rd_data;
            state_d = S_TWO;
          end
          2'b01: state_d = S_EMPTY;
          2'b11: head_d  = fifo_rd_data;
          default: ;
        endcase
      end
      S_TWO: begin
        // push without pop cannot occur here because reads stop once both slots are committed
        if (pop) begin
          head_d = skid_q;
          if (push) skid_d  = fifo_rd_data;
          else      state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Buffer and read-in-flight registers. Reset discards all words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Delivered words and stalled cycles. Both counters wrap naturally.
  always_comb begin
    word_cnt_d  = word_cnt_q  + CNT_WIDTH'(pop);
    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(m_valid & ~m_ready);
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign word_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule
